// File: rtl/r_line_io_bridge.sv
// r_line_io_bridge: board-side peripheral on the CPU R/O/K pins.
// Synchronizes the CPU strobes and raw key switches, debounces an 11x4 key
// matrix and returns K lines, captures settled O values into a per-digit
// buffer, and refreshes a multiplexed active-low 7-segment display.
module r_line_io_bridge #(
  parameter int          NUM_DIGITS      = 8,
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd24000,
  parameter logic [7:0]  SETTLE_CYCLES   = 8'd48,
  parameter logic [15:0] REFRESH_CYCLES  = 16'd12000,
  parameter logic [7:0]  BLANK_CYCLES    = 8'd24
) (
  input  logic                  raw_clk,
  input  logic                  button_reset,
  input  logic [10:0]           pins_r,
  input  logic [7:0]            pins_o,
  input  logic [43:0]           keys,
  output logic [3:0]            pins_k,
  output logic [7:0]            seg,
  output logic [NUM_DIGITS-1:0] digit_sel,
  output logic [43:0]           key_state
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_t;

  // synchronizer chains
  logic [10:0] r_meta_q, r_s_q;
  logic [7:0]  o_meta_q, o_s_q;
  logic [43:0] k_meta_q, k_s_q;

  // debounce
  logic [15:0] db_cnt_q [44];
  logic [15:0] db_cnt_d [44];
  logic [43:0] key_state_q, key_state_d;

  // K return
  logic [3:0]  pins_k_q, pins_k_d;

  // digit capture; segment bit 7 is never displayed, so only seven bits are kept
  logic [10:0] r_prev_q;
  logic [7:0]  o_prev_q;
  logic [7:0]  settle_cnt_q, settle_cnt_d;
  logic        changed, settled;
  logic [6:0]  digit_buf_q [NUM_DIGITS];
  logic [6:0]  digit_buf_d [NUM_DIGITS];

  // scan
  scan_state_t           state_q, state_d;
  logic [15:0]           scan_cnt_q, scan_cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  shown_q, shown_d;
  logic [7:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] digit_sel_q, digit_sel_d;

  // Two-flop synchronizers for every asynchronous input bus
  always_ff @(posedge raw_clk or negedge button_reset) begin
    if (!button_reset) begin
      r_meta_q <= '0;
      r_s_q    <= '0;
      o_meta_q <= '0;
      o_s_q    <= '0;
      k_meta_q <= '0;
      k_s_q    <= '0;
    end else begin
      r_meta_q <= pins_r;
      r_s_q    <= r_meta_q;
      o_meta_q <= pins_o;
      o_s_q    <= o_meta_q;
      k_meta_q <= keys;
      k_s_q    <= k_meta_q;
    end
  end

  // Per-key debounce: count consecutive disagreeing samples, flip on the last one
  always_comb begin
    key_state_d = key_state_q;
    for (int i = 0; i < 44; i++) begin
      db_cnt_d[i] = 16'd0;
      if (k_s_q[i] != key_state_q[i]) begin
        if (db_cnt_q[i] == DEBOUNCE_CYCLES - 16'd1) begin
          key_state_d[i] = ~key_state_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 16'd1;
        end
      end
    end
  end

  // Debounce state registers
  always_ff @(posedge raw_clk or negedge button_reset) begin
    if (!button_reset) begin
      key_state_q <= '0;
      for (int i = 0; i < 44; i++) begin
        db_cnt_q[i] <= 16'd0;
      end
    end else begin
      key_state_q <= key_state_d;
      for (int i = 0; i < 44; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
    end
  end

  // K return: OR of the debounced columns of every strobed R line
  always_comb begin
    pins_k_d = '0;
    for (int r = 0; r < 11; r++) begin
      for (int k = 0; k < 4; k++) begin
        pins_k_d[k] = pins_k_d[k] | (r_s_q[r] & key_state_q[r*4+k]);
      end
    end
  end

  // K return register
  always_ff @(posedge raw_clk or negedge button_reset) begin
    if (!button_reset) begin
      pins_k_q <= '0;
    end else begin
      pins_k_q <= pins_k_d;
    end
  end

  // Settle tracking and capture; a change this cycle blocks capture even while the count is still full
  always_comb begin
    changed      = (r_s_q != r_prev_q) || (o_s_q != o_prev_q);
    settle_cnt_d = settle_cnt_q;
    if (changed) begin
      settle_cnt_d = 8'd0;
    end else if (settle_cnt_q != SETTLE_CYCLES) begin
      settle_cnt_d = settle_cnt_q + 8'd1;
    end
    settled = (settle_cnt_q == SETTLE_CYCLES) && !changed;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      digit_buf_d[d] = digit_buf_q[d];
      if (settled && r_s_q[d]) begin
        digit_buf_d[d] = o_s_q[6:0];
      end
    end
  end

  // Capture registers and previous-cycle copies of R and O
  always_ff @(posedge raw_clk or negedge button_reset) begin
    if (!button_reset) begin
      r_prev_q     <= '0;
      o_prev_q     <= '0;
      settle_cnt_q <= 8'd0;
      for (int d = 0; d < NUM_DIGITS; d++) begin
        digit_buf_q[d] <= 7'd0;
      end
    end else begin
      r_prev_q     <= r_s_q;
      o_prev_q     <= o_s_q;
      settle_cnt_q <= settle_cnt_d;
      for (int d = 0; d < NUM_DIGITS; d++) begin
        digit_buf_q[d] <= digit_buf_d[d];
      end
    end
  end

  // Scan next-state: lit digit for REFRESH cycles, dark gap for BLANK cycles; the very first gap keeps idx at 0
  always_comb begin
    state_d     = state_q;
    scan_cnt_d  = scan_cnt_q;
    idx_d       = idx_q;
    shown_d     = shown_q;
    seg_d       = 8'hff;
    digit_sel_d = '1;
    case (state_q)
      ST_SHOW: begin
        seg_d       = {1'b1, ~digit_buf_q[idx_q]};
        digit_sel_d = ~(NUM_DIGITS'(1) << idx_q);
        if (scan_cnt_q == REFRESH_CYCLES - 16'd1) begin
          state_d    = ST_BLANK;
          scan_cnt_d = 16'd0;
        end else begin
          scan_cnt_d = scan_cnt_q + 16'd1;
        end
      end
      default: begin
        if (scan_cnt_q == {8'd0, BLANK_CYCLES} - 16'd1) begin
          state_d    = ST_SHOW;
          scan_cnt_d = 16'd0;
          shown_d    = 1'b1;
          if (shown_q) begin
            idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
          end
        end else begin
          scan_cnt_d = scan_cnt_q + 16'd1;
        end
      end
    endcase
  end

  // Scan FSM with registered display outputs
  always_ff @(posedge raw_clk or negedge button_reset) begin
    if (!button_reset) begin
      state_q     <= ST_BLANK;
      scan_cnt_q  <= 16'd0;
      idx_q       <= '0;
      shown_q     <= 1'b0;
      seg_q       <= 8'hff;
      digit_sel_q <= '1;
    end else begin
      state_q     <= state_d;
      scan_cnt_q  <= scan_cnt_d;
      idx_q       <= idx_d;
      shown_q     <= shown_d;
      seg_q       <= seg_d;
      digit_sel_q <= digit_sel_d;
    end
  end

  assign pins_k    = pins_k_q;
  assign key_state = key_state_q;
  assign seg       = seg_q;
  assign digit_sel = digit_sel_q;

endmodule

// File: tb/tb_r_line_io_bridge.sv
// tb_r_line_io_bridge: directed stimulus with a cycle-stamped scoreboard.
// Stimulus pushes expected output values tagged with the cycle they must
// appear on; a monitor on the falling edge pops and compares them.
module tb_r_line_io_bridge;

  localparam int ND = 8;
  localparam int DB = 200;
  localparam int SE = 48;
  localparam int RF = 200;
  localparam int BL = 24;
  localparam int P  = RF + BL;

  logic          raw_clk      = 1'b0;
  logic          button_reset = 1'b1;
  logic [10:0]   pins_r       = '0;
  logic [7:0]    pins_o       = '0;
  logic [43:0]   keys         = '0;
  logic [3:0]    pins_k;
  logic [7:0]    seg;
  logic [ND-1:0] digit_sel;
  logic [43:0]   key_state;

  r_line_io_bridge #(
    .NUM_DIGITS(ND),
    .DEBOUNCE_CYCLES(16'(DB)),
    .SETTLE_CYCLES(8'(SE)),
    .REFRESH_CYCLES(16'(RF)),
    .BLANK_CYCLES(8'(BL))
  ) dut (
    .raw_clk(raw_clk),
    .button_reset(button_reset),
    .pins_r(pins_r),
    .pins_o(pins_o),
    .keys(keys),
    .pins_k(pins_k),
    .seg(seg),
    .digit_sel(digit_sel),
    .key_state(key_state)
  );

  always #5 raw_clk = ~raw_clk;

  int cyc = 0;
  always @(posedge raw_clk) cyc <= cyc + 1;

  typedef struct {
    int          at;
    int          kind;
    logic [63:0] val;
    string       name;
  } exp_t;

  exp_t        sb_q[$];
  int          total = 0;
  int          bad = 0;
  int          rel_cyc = 0;
  logic [7:0]  bufm [ND];
  logic [63:0] ks_exp;
  logic [63:0] blank_exp;

  function automatic logic [63:0] actual_of(int kind);
    if (kind == 0) return {48'd0, seg, digit_sel};
    if (kind == 1) return {60'd0, pins_k};
    return {20'd0, key_state};
  endfunction

  // Display model: time since reset release decides lit digit or dark gap
  function automatic logic [63:0] model_disp(int c);
    int t, n, off, d;
    logic [7:0]    s;
    logic [ND-1:0] sel;
    t = c - rel_cyc - (BL + 1);
    if (t < 0) return {48'd0, 8'hff, {ND{1'b1}}};
    n   = t / P;
    off = t % P;
    if (off >= RF) return {48'd0, 8'hff, {ND{1'b1}}};
    d      = n % ND;
    sel    = '1;
    sel[d] = 1'b0;
    s      = {1'b1, ~bufm[d][6:0]};
    return {48'd0, s, sel};
  endfunction

  task automatic check_output(input string name, input int at, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("[TB] FAIL %s @cycle %0d: got %h expected %h", name, at, act, expv);
    end
  endtask

  task automatic push_exp(input int at, input int kind, input logic [63:0] v, input string nm);
    exp_t e;
    e.at   = at;
    e.kind = kind;
    e.val  = v;
    e.name = nm;
    sb_q.push_back(e);
  endtask

  task automatic push_disp(input int at, input string nm);
    push_exp(at, 0, model_disp(at), nm);
  endtask

  task automatic apply_stimulus(input logic [10:0] r, input logic [7:0] o);
    pins_r = r;
    pins_o = o;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge raw_clk);
  endtask

  task automatic drain(input int limit);
    int w;
    w = 0;
    while (sb_q.size() != 0 && w < limit) begin
      @(negedge raw_clk);
      w++;
    end
    if (sb_q.size() != 0) begin
      foreach (sb_q[i]) begin
        total++;
        bad++;
        $display("[TB] FAIL %s: not sampled by cycle %0d, got none expected %h", sb_q[i].name, cyc, sb_q[i].val);
      end
      sb_q.delete();
    end
  endtask

  // Monitor: compare every expectation stamped for the current cycle
  always @(negedge raw_clk) begin
    for (int i = sb_q.size() - 1; i >= 0; i--) begin
      if (sb_q[i].at < cyc) begin
        total++;
        bad++;
        $display("[TB] FAIL %s: cycle %0d passed, got none expected %h", sb_q[i].name, sb_q[i].at, sb_q[i].val);
        sb_q.delete(i);
      end else if (sb_q[i].at == cyc) begin
        check_output(sb_q[i].name, cyc, actual_of(sb_q[i].kind), sb_q[i].val);
        sb_q.delete(i);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int c, n, s;
    logic [10:0] r_tab [5];
    logic [3:0]  k_tab [5];
    logic [3:0]  k_prev;

    ks_exp     = 64'd0;
    ks_exp[9]  = 1'b1;
    ks_exp[23] = 1'b1;
    blank_exp  = {48'd0, 8'hff, 8'hff};
    for (int d = 0; d < ND; d++) bufm[d] = 8'h00;

    #1 button_reset = 1'b0;
    wait_cycles(1);
    $display("[TB] reset values");
    push_exp(cyc + 2, 0, blank_exp, "reset_display");
    push_exp(cyc + 2, 1, 64'd0, "reset_pins_k");
    push_exp(cyc + 2, 2, 64'd0, "reset_key_state");
    drain(10);

    button_reset = 1'b1;
    rel_cyc = cyc;
    push_disp(rel_cyc + BL, "first_gap_end");
    push_disp(rel_cyc + BL + 1, "first_show_digit0");
    push_disp(rel_cyc + BL + RF, "digit0_last_lit");
    push_disp(rel_cyc + BL + RF + 1, "digit0_gap");
    push_disp(rel_cyc + BL + 1 + P, "digit1_first_lit");

    $display("[TB] debounce");
    c = cyc;
    keys[9]  = 1'b1;
    keys[23] = 1'b1;
    push_exp(c + DB + 1, 2, 64'd0, "debounce_one_early");
    push_exp(c + DB + 2, 2, ks_exp, "debounce_set");
    wait_cycles(DB + 5);
    keys[0] = 1'b1;
    wait_cycles(100);
    keys[0] = 1'b0;
    push_exp(cyc + DB + 5, 2, ks_exp, "glitch_100_ignored");
    c = cyc;
    keys[1] = 1'b1;
    wait_cycles(DB - 1);
    keys[1] = 1'b0;
    push_exp(c + DB + 2, 2, ks_exp, "glitch_db_minus_1_edge");
    push_exp(c + DB + 10, 2, ks_exp, "glitch_db_minus_1_after");
    drain(DB + 50);

    $display("[TB] K return");
    r_tab[0] = 11'h004; k_tab[0] = 4'b0010;
    r_tab[1] = 11'h020; k_tab[1] = 4'b1000;
    r_tab[2] = 11'h024; k_tab[2] = 4'b1010;
    r_tab[3] = 11'h080; k_tab[3] = 4'b0000;
    r_tab[4] = 11'h000; k_tab[4] = 4'b0000;
    k_prev = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      c = cyc;
      apply_stimulus(r_tab[i], 8'h00);
      push_exp(c + 2, 1, {60'd0, k_prev}, $sformatf("k_return_%0d_hold", i));
      push_exp(c + 3, 1, {60'd0, k_tab[i]}, $sformatf("k_return_%0d", i));
      wait_cycles(6);
      k_prev = k_tab[i];
    end
    drain(10);

    $display("[TB] capture");
    apply_stimulus(11'h008, 8'h79);
    wait_cycles(60);
    bufm[3] = 8'h79;
    apply_stimulus(11'h000, 8'h5b);
    wait_cycles(60);
    apply_stimulus(11'h008, 8'h06);
    for (int i = 0; i < 10; i++) begin
      wait_cycles(20);
      pins_o = (pins_o == 8'h06) ? 8'h5b : 8'h06;
    end
    wait_cycles(20);
    apply_stimulus(11'h000, 8'h00);
    wait_cycles(60);
    apply_stimulus(11'h200, 8'h30);
    wait_cycles(100);
    apply_stimulus(11'h000, 8'h00);
    wait_cycles(60);

    $display("[TB] scan pass");
    n = (cyc - rel_cyc - BL - 1) / P + 2;
    for (int j = n; j < n + ND + 1; j++) begin
      s = rel_cyc + BL + 1 + j * P;
      push_disp(s - 1, $sformatf("scan_d%0d_gap_before", j % ND));
      push_disp(s, $sformatf("scan_d%0d_first", j % ND));
      push_disp(s + RF - 1, $sformatf("scan_d%0d_last", j % ND));
      push_disp(s + RF, $sformatf("scan_d%0d_gap_after", j % ND));
    end
    drain((ND + 4) * P);

    $display("[TB] reset mid-show");
    n = (cyc - rel_cyc - BL - 1) / P + 1;
    while (n % ND != 3) n++;
    s = rel_cyc + BL + 1 + n * P;
    push_disp(s + 49, "pre_reset_digit3");
    while (cyc < s + 50) @(negedge raw_clk);
    button_reset = 1'b0;
    push_exp(cyc + 1, 0, blank_exp, "mid_reset_display");
    push_exp(cyc + 1, 1, 64'd0, "mid_reset_pins_k");
    push_exp(cyc + 1, 2, 64'd0, "mid_reset_key_state");
    wait_cycles(3);
    button_reset = 1'b1;
    rel_cyc = cyc;
    for (int d = 0; d < ND; d++) bufm[d] = 8'h00;
    push_disp(rel_cyc + BL, "rerelease_gap_end");
    push_disp(rel_cyc + BL + 1, "rerelease_digit0");
    push_disp(rel_cyc + BL + 1 + 3 * P, "rerelease_digit3_cleared");
    push_exp(rel_cyc + DB + 1, 2, 64'd0, "rerelease_keys_early");
    push_exp(rel_cyc + DB + 2, 2, ks_exp, "rerelease_keys_set");
    drain(6 * P);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/r_line_io_bridge.md
Name: r_line_io_bridge

Overview:
- Peripheral at the far end of the CPU R/O/K pin interface.
- Consumes the R strobe lines and O segment lines driven by the processor core, and returns K lines from a debounced 11x4 key matrix.
- Latches the O value for each strobed R digit into a digit buffer.
- Independently refreshes a multiplexed, active-low 7-segment LED display from that buffer.
- Sits on the board between the soft processor and the physical keys/display; all logic runs on raw_clk.

Parameters:
- NUM_DIGITS, 8: R lines 0..NUM_DIGITS-1 that are treated as display digits (1..11).
- DEBOUNCE_CYCLES, 16'd24000: stable-sample count before a key's debounced state changes (2 ms at 12 MHz).
- SETTLE_CYCLES, 8'd48: cycles R and O must be unchanged before a digit capture.
- REFRESH_CYCLES, 16'd12000: cycles each digit is lit.
- BLANK_CYCLES, 8'd24: all-off gap between digits.

Ports:
- raw_clk  input  1  system clock (12 MHz).
- button_reset  input  1  asynchronous active-low reset.
- pins_r  input  11  R strobe outputs of the CPU.
- pins_o  input  8  O outputs of the CPU (segment data).
- keys  input  44  raw switches, active-high pressed; bit index r*4+k (R line r, K line k).
- pins_k  output  4  K inputs returned to the CPU.
- seg  output  8  display segments, active-low; bit 7 unused, driven 1.
- digit_sel  output  NUM_DIGITS  digit enables, active-low.
- key_state  output  44  debounced key vector (debug).

Behaviour:
- Reset (async, button_reset=0):
  - pins_k=0, key_state=0.
  - digit buffer all 0.
  - seg=8'hff, digit_sel all 1.
  - Scan FSM in BLANK with idx=0; all counters 0; synchronizer flops 0.
- Synchronizers: pins_r, pins_o and keys each pass through two flops (r_s, o_s, k_s). All logic below uses the synchronized values.
- Debounce, per key i:
  - 16-bit counter cleared whenever k_s[i]==key_state[i].
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1, key_state[i] toggles and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES never changes key_state.
- K return: registered. pins_k[k] <= OR over r=0..10 of (r_s[r] & key_state[r*4+k]).
  - Latency from a pins_r edge to a pins_k change is 3 raw_clk cycles.
  - Multiple R lines high give the OR of their columns.
- Digit capture:
  - Settle counter (8-bit) clears whenever r_s or o_s differs from its previous-cycle value; otherwise it increments and saturates at SETTLE_CYCLES.
  - While the counter == SETTLE_CYCLES, every d<NUM_DIGITS with r_s[d]=1 loads o_s into buf[d] each cycle (idempotent).
  - R lines >= NUM_DIGITS never capture.
  - Several strobed digits all receive the same value.
  - The CLO case (all R=0) captures nothing; buffers hold.
- Scan FSM: two states, SHOW and BLANK.
  - SHOW: digit_sel = ~(1<<idx); seg = {1'b1, ~buf[idx][6:0]}. Stays for REFRESH_CYCLES cycles, then goes to BLANK with counter cleared.
  - BLANK: digit_sel all 1, seg=8'hff. Stays for BLANK_CYCLES cycles.
  - On leaving BLANK: idx <= (idx==NUM_DIGITS-1) ? 0 : idx+1, then enter SHOW.
  - First SHOW after reset is digit 0, after BLANK_CYCLES cycles.
  - seg and digit_sel are registered, so output changes appear 1 cycle after a state change.
- Simultaneous events:
  - A capture into buf[idx] while digit idx is in SHOW updates seg on the next cycle; no glitch-free hold is required.
  - Debounce, capture and scan are independent and never stall one another.
- Reset mid-operation: all state returns to reset values immediately. Release is synchronous to raw_clk through the normal flop behaviour; no key or digit state survives.

Test Plan:
- Reset check: assert button_reset=0 mid-SHOW -> next sample shows seg=8'hff, digit_sel=8'hff, pins_k=0, key_state=0. After release, digit 0 SHOW begins BLANK_CYCLES+1 cycles later.
- Key debounce: keys[4*2+1]=1 held → key_state[9]=1 exactly DEBOUNCE_CYCLES+2 cycles later. A 100-cycle pulse on keys[0] → key_state stays 0.
- K return: key_state[9]=1, drive pins_r=11'b100 → pins_k=4'b0010 three cycles later. pins_r=0 → pins_k=0 three cycles later.
- Capture: pins_r=11'b1000, pins_o=8'h79 held 60 cycles → buf[3]=8'h79. When scan reaches idx 3: digit_sel=8'b11110111, seg=8'h86.
- Capture rejection: pins_o toggled every 20 cycles while pins_r[3]=1 → buf[3] unchanged. pins_r[9]=1 with pins_o=8'h30 → no buffer changes.
- Scan wrap: observe a full refresh pass → digit order 0..7 then 0. Each SHOW is REFRESH_CYCLES long, separated by BLANK_CYCLES all-off gaps.
